// File: rtl/wd_supervisor_if.sv
// wd_supervisor_if: liveness sources, watchdog controls and status of the supervisor (WD_SUPERVISOR_STATS_EN adds counters)
interface wd_supervisor_if #(parameter int N_SRC = 4);
    logic             arm;
    logic [N_SRC-1:0] src_mask;
    logic [N_SRC-1:0] src_beat;
    logic             clear_lockout;
    logic             wd_triggered;
    logic             wd_enable;
    logic             wd_heartbeat;
    logic             wd_force_reset;
    logic             rf_mute;
    logic             lockout;
    logic [2:0]       state;
    logic [2:0]       retry_count;
    logic [N_SRC-1:0] missed_src;
`ifdef WD_SUPERVISOR_STATS_EN
    logic [15:0]      fault_count;
    logic [15:0]      miss_count;
`endif
    modport master (
`ifdef WD_SUPERVISOR_STATS_EN
        input  fault_count, miss_count,
`endif
        output arm, src_mask, src_beat, clear_lockout, wd_triggered,
        input  wd_enable, wd_heartbeat, wd_force_reset, rf_mute, lockout, state, retry_count, missed_src
    );
    modport slave (
`ifdef WD_SUPERVISOR_STATS_EN
        output fault_count, miss_count,
`endif
        input  arm, src_mask, src_beat, clear_lockout, wd_triggered,
        output wd_enable, wd_heartbeat, wd_force_reset, rf_mute, lockout, state, retry_count, missed_src
    );
endinterface

// File: rtl/wd_supervisor.sv
// wd_supervisor: gates watchdog heartbeats on all masked sources checking in per round; fault hold-off, retry and lockout (WD_SUPERVISOR_STATS_EN adds fault/miss counters)
module wd_supervisor #(
    parameter int N_SRC          = 4,
    parameter int ROUND_CYCLES   = 1000,
    parameter int HOLDOFF_CYCLES = 125000,
    parameter int MAX_RETRIES    = 3
) (
    input logic         clk,
    input logic         rst,
    wd_supervisor_if.slave bus
);
    localparam int RW = $clog2(ROUND_CYCLES + 1);
    localparam int HW = $clog2(HOLDOFF_CYCLES + 1);

    typedef enum logic [2:0] {IDLE = 3'd0, ARMING = 3'd1, RUN = 3'd2, FAULT_HOLD = 3'd3, LOCKOUT = 3'd4} state_t;

    state_t           state_q, state_d;
    logic [N_SRC-1:0] seen_q, seen_d, seen_next, missed_q, missed_d;
    logic [RW-1:0]    round_q, round_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic [2:0]       retry_q, retry_d;
    logic             hb_q, hb_d, complete, fault, timeout;

    // next-state, round bookkeeping and retry accounting
    always_comb begin
        seen_next = seen_q | (bus.src_beat & bus.src_mask);
        complete  = (seen_next & bus.src_mask) == bus.src_mask;
        state_d   = state_q;
        seen_d    = seen_q;
        round_d   = round_q;
        hold_d    = '0;
        retry_d   = retry_q;
        missed_d  = missed_q;
        hb_d      = 1'b0;
        fault     = 1'b0;
        timeout   = 1'b0;
        case (state_q)
            IDLE: state_d = (bus.arm && |bus.src_mask) ? ARMING : IDLE;
            ARMING: begin
                state_d  = RUN;
                seen_d   = '0;
                round_d  = '0;
                missed_d = '0;
            end
            RUN: begin
                if (bus.wd_triggered) begin
                    state_d = FAULT_HOLD;
                    fault   = 1'b1;
                    retry_d = (retry_q == 3'(MAX_RETRIES)) ? retry_q : retry_q + 3'd1;
                end else if (!bus.arm) begin
                    state_d = IDLE;
                end else if (complete) begin
                    hb_d    = 1'b1;
                    seen_d  = '0;
                    round_d = '0;
                end else if (round_q == RW'(ROUND_CYCLES - 1)) begin
                    timeout  = 1'b1;
                    missed_d = bus.src_mask & ~seen_next;
                    seen_d   = '0;
                    round_d  = '0;
                end else begin
                    seen_d  = seen_next;
                    round_d = round_q + RW'(1);
                end
            end
            FAULT_HOLD: begin
                if (hold_q == HW'(HOLDOFF_CYCLES - 1))
                    state_d = (retry_q == 3'(MAX_RETRIES)) ? LOCKOUT : bus.arm ? ARMING : IDLE;
                else
                    hold_d = hold_q + HW'(1);
            end
            LOCKOUT: state_d = bus.clear_lockout ? IDLE : LOCKOUT;
            default: state_d = IDLE;
        endcase
        if (state_d == IDLE)
            retry_d = '0;
    end

    // state and bookkeeping registers; outputs registered from the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q            <= IDLE;
            seen_q             <= '0;
            round_q            <= '0;
            hold_q             <= '0;
            retry_q            <= '0;
            missed_q           <= '0;
            hb_q               <= 1'b0;
            bus.wd_enable      <= 1'b0;
            bus.wd_force_reset <= 1'b0;
            bus.rf_mute        <= 1'b1;
            bus.lockout        <= 1'b0;
        end else begin
            state_q            <= state_d;
            seen_q             <= seen_d;
            round_q            <= round_d;
            hold_q             <= hold_d;
            retry_q            <= retry_d;
            missed_q           <= missed_d;
            hb_q               <= hb_d;
            bus.wd_enable      <= state_d == RUN;
            bus.wd_force_reset <= state_d == ARMING;
            bus.rf_mute        <= state_d != RUN;
            bus.lockout        <= state_d == LOCKOUT;
        end
    end

    assign bus.state        = state_q;
    assign bus.retry_count  = retry_q;
    assign bus.missed_src   = missed_q;
    assign bus.wd_heartbeat = hb_q;

`ifdef WD_SUPERVISOR_STATS_EN
    logic [15:0] fault_cnt_q, fault_cnt_d, miss_cnt_q, miss_cnt_d;

    // saturating fault and round-timeout counters
    always_comb begin
        fault_cnt_d = fault_cnt_q + 16'(fault && !(&fault_cnt_q));
        miss_cnt_d  = miss_cnt_q + 16'(timeout && !(&miss_cnt_q));
    end

    // counter registers, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_cnt_q <= '0;
            miss_cnt_q  <= '0;
        end else begin
            fault_cnt_q <= fault_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
        end
    end

    assign bus.fault_count = fault_cnt_q;
    assign bus.miss_count  = miss_cnt_q;
`else
    logic unused_stats;
    assign unused_stats = fault ^ timeout;
`endif
endmodule

// File: tb/tb_wd_supervisor.sv
// tb_wd_supervisor: directed scenarios plus randomized run against a cycle-level reference model
module tb_wd_supervisor;
    localparam int NS = 4, RC = 16, HC = 8, MR = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_cmp = 0;
    int n_bad = 0;

    wd_supervisor_if #(.N_SRC(NS)) bus();

    wd_supervisor #(.N_SRC(NS), .ROUND_CYCLES(RC), .HOLDOFF_CYCLES(HC), .MAX_RETRIES(MR))
        dut (.clk(clk), .rst(rst), .bus(bus.slave));

    always #5 clk = ~clk;

    // reference model state: mode number as listed in the state encoding
    int       m_state, m_round, m_hold, m_retry, m_faults, m_misses;
    bit [3:0] m_seen, m_missed;
    bit       m_hb;

    task automatic model_reset();
        m_state = 0; m_round = 0; m_hold = 0; m_retry = 0;
        m_seen = 0; m_missed = 0; m_hb = 0; m_faults = 0; m_misses = 0;
    endtask

    task automatic model_step();
        bit [3:0] mask, got;
        bit done;
        mask = bus.src_mask;
        got  = m_seen | (bus.src_beat & mask);
        done = (got & mask) == mask;
        m_hb = 0;
        if (m_state == 0) begin
            if (bus.arm && mask != 0) m_state = 1;
        end else if (m_state == 1) begin
            m_seen = 0; m_round = 0; m_missed = 0; m_state = 2;
        end else if (m_state == 2) begin
            if (bus.wd_triggered) begin
                m_state = 3; m_hold = 0;
                m_retry = (m_retry < MR) ? m_retry + 1 : m_retry;
                m_faults = (m_faults < 65535) ? m_faults + 1 : m_faults;
            end else if (!bus.arm) m_state = 0;
            else if (done) begin
                m_hb = 1; m_seen = 0; m_round = 0;
            end else if (m_round == RC - 1) begin
                m_missed = mask & ~got; m_seen = 0; m_round = 0;
                m_misses = (m_misses < 65535) ? m_misses + 1 : m_misses;
            end else begin
                m_seen = got; m_round++;
            end
        end else if (m_state == 3) begin
            if (m_hold == HC - 1) m_state = (m_retry == MR) ? 4 : (bus.arm ? 1 : 0);
            else m_hold++;
        end else if (bus.clear_lockout) m_state = 0;
        if (m_state == 0) m_retry = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset(); else model_step();
        #1;
    endtask

    task automatic test_reset();
        bus.arm = 0; bus.src_mask = 0; bus.src_beat = 0; bus.clear_lockout = 0; bus.wd_triggered = 0;
        rst = 1;
        repeat (3) tick();
        rst = 0;
        n_cmp++; if (bus.state !== 3'd0) begin n_bad++; $display("FAIL reset_state got=%0d exp=0", bus.state); end
        n_cmp++; if (bus.rf_mute !== 1'b1) begin n_bad++; $display("FAIL reset_mute got=%b exp=1", bus.rf_mute); end
        n_cmp++;
        if ({bus.wd_enable, bus.wd_heartbeat, bus.wd_force_reset, bus.lockout, bus.retry_count, bus.missed_src} !== 11'd0) begin
            n_bad++; $display("FAIL reset_zero got en=%b hb=%b frc=%b lock=%b retry=%0d missed=%b exp all 0",
                              bus.wd_enable, bus.wd_heartbeat, bus.wd_force_reset, bus.lockout, bus.retry_count, bus.missed_src);
        end
    endtask

    task automatic test_arm();
        bus.arm = 1; bus.src_mask = 4'b1111;
        tick();
        n_cmp++; if (bus.state !== 3'd1) begin n_bad++; $display("FAIL arm_state1 got=%0d exp=1", bus.state); end
        n_cmp++; if (bus.wd_force_reset !== 1'b1) begin n_bad++; $display("FAIL arm_frc_hi got=%b exp=1", bus.wd_force_reset); end
        n_cmp++; if (bus.rf_mute !== 1'b1) begin n_bad++; $display("FAIL arm_mute_hi got=%b exp=1", bus.rf_mute); end
        tick();
        n_cmp++; if (bus.state !== 3'd2) begin n_bad++; $display("FAIL arm_state2 got=%0d exp=2", bus.state); end
        n_cmp++; if (bus.wd_force_reset !== 1'b0) begin n_bad++; $display("FAIL arm_frc_lo got=%b exp=0", bus.wd_force_reset); end
        n_cmp++; if ({bus.rf_mute, bus.wd_enable} !== 2'b01) begin n_bad++; $display("FAIL arm_run_out got=%b%b exp=01", bus.rf_mute, bus.wd_enable); end
    endtask

    task automatic test_heartbeat();
        for (int k = 0; k < 10; k++) begin
            bus.src_beat = (k == 2) ? 4'b0001 : (k == 5) ? 4'b0010 : (k == 7) ? 4'b0100 : (k == 9) ? 4'b1000 : 4'b0000;
            tick();
            bus.src_beat = 0;
            n_cmp++;
            if (bus.wd_heartbeat !== (k == 9)) begin n_bad++; $display("FAIL hb_cycle%0d got=%b exp=%b", k + 1, bus.wd_heartbeat, k == 9); end
        end
    endtask

    task automatic test_timeout();
        for (int r = 0; r < RC; r++) begin
            bus.src_beat = (r == 1) ? 4'b0001 : (r == 2) ? 4'b0010 : (r == 3) ? 4'b1000 : 4'b0000;
            tick();
            bus.src_beat = 0;
            n_cmp++; if (bus.wd_heartbeat !== 1'b0) begin n_bad++; $display("FAIL to_hb r=%0d got=%b exp=0", r, bus.wd_heartbeat); end
            n_cmp++;
            if (bus.missed_src !== ((r == RC - 1) ? 4'b0100 : 4'b0000)) begin
                n_bad++; $display("FAIL to_missed r=%0d got=%b exp=%b", r, bus.missed_src, (r == RC - 1) ? 4'b0100 : 4'b0000);
            end
        end
        bus.src_beat = 4'b1111;
        tick();
        bus.src_beat = 0;
        n_cmp++; if (bus.wd_heartbeat !== 1'b1) begin n_bad++; $display("FAIL to_restart_hb got=%b exp=1", bus.wd_heartbeat); end
    endtask

    task automatic test_fault();
        bus.wd_triggered = 1; bus.arm = 0; bus.src_beat = 4'b1111;
        tick();
        bus.wd_triggered = 0; bus.src_beat = 0; bus.arm = 1;
        n_cmp++; if (bus.state !== 3'd3) begin n_bad++; $display("FAIL fault_state got=%0d exp=3", bus.state); end
        n_cmp++; if (bus.retry_count !== 3'd1) begin n_bad++; $display("FAIL fault_retry got=%0d exp=1", bus.retry_count); end
        n_cmp++;
        if ({bus.wd_heartbeat, bus.wd_enable, bus.rf_mute} !== 3'b001) begin
            n_bad++; $display("FAIL fault_out got hb=%b en=%b mute=%b exp 0 0 1", bus.wd_heartbeat, bus.wd_enable, bus.rf_mute);
        end
        repeat (HC - 1) tick();
        n_cmp++; if (bus.state !== 3'd3) begin n_bad++; $display("FAIL hold_len got=%0d exp=3", bus.state); end
        tick();
        n_cmp++; if (bus.state !== 3'd1) begin n_bad++; $display("FAIL hold_rearm got=%0d exp=1", bus.state); end
        n_cmp++; if (bus.retry_count !== 3'd1) begin n_bad++; $display("FAIL hold_retry got=%0d exp=1", bus.retry_count); end
        tick();
    endtask

    task automatic test_lockout();
        bus.wd_triggered = 1;
        tick();
        bus.wd_triggered = 0;
        n_cmp++; if (bus.retry_count !== 3'd2) begin n_bad++; $display("FAIL lock_retry got=%0d exp=2", bus.retry_count); end
        repeat (HC) tick();
        n_cmp++; if (bus.state !== 3'd4) begin n_bad++; $display("FAIL lock_state got=%0d exp=4", bus.state); end
        n_cmp++;
        if ({bus.lockout, bus.rf_mute, bus.wd_enable} !== 3'b110) begin
            n_bad++; $display("FAIL lock_out got lock=%b mute=%b en=%b exp 1 1 0", bus.lockout, bus.rf_mute, bus.wd_enable);
        end
        for (int i = 0; i < 6; i++) begin
            bus.arm = i[0];
            tick();
        end
        n_cmp++; if (bus.state !== 3'd4) begin n_bad++; $display("FAIL lock_arm_ignored got=%0d exp=4", bus.state); end
        bus.arm = 0; bus.clear_lockout = 1;
        tick();
        bus.clear_lockout = 0;
        n_cmp++; if (bus.state !== 3'd0) begin n_bad++; $display("FAIL clear_state got=%0d exp=0", bus.state); end
        n_cmp++;
        if ({bus.retry_count, bus.lockout} !== 4'd0) begin
            n_bad++; $display("FAIL clear_out got retry=%0d lock=%b exp 0 0", bus.retry_count, bus.lockout);
        end
    endtask

    task automatic test_async_reset();
        bus.arm = 1;
        tick(); tick();
        bus.wd_triggered = 1;
        tick();
        bus.wd_triggered = 0;
        tick();
        n_cmp++; if (bus.state !== 3'd3) begin n_bad++; $display("FAIL ares_pre got=%0d exp=3", bus.state); end
        #2 rst = 1;
        model_reset();
        #1;
        n_cmp++;
        if ({bus.state, bus.rf_mute, bus.wd_enable, bus.retry_count, bus.lockout} !== {3'd0, 1'b1, 1'b0, 3'd0, 1'b0}) begin
            n_bad++; $display("FAIL ares_out got state=%0d mute=%b en=%b retry=%0d lock=%b exp 0 1 0 0 0",
                              bus.state, bus.rf_mute, bus.wd_enable, bus.retry_count, bus.lockout);
        end
`ifdef WD_SUPERVISOR_STATS_EN
        n_cmp++; if (bus.fault_count !== 16'd0) begin n_bad++; $display("FAIL ares_fault_count got=%0d exp=0", bus.fault_count); end
`endif
        tick();
        rst = 0;
    endtask

    task automatic test_random();
        logic [14:0] got, exp;
        for (int c = 0; c < 4000; c++) begin
            bus.arm = $urandom_range(0, 99) < 95;
            if ($urandom_range(0, 19) == 0) bus.src_mask = 4'($urandom_range(0, 15));
            bus.src_beat = {$urandom_range(0, 9) < 3, $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 3};
            bus.wd_triggered = $urandom_range(0, 149) == 0;
            bus.clear_lockout = $urandom_range(0, 29) == 0;
            tick();
            got = {bus.state, bus.retry_count, bus.missed_src, bus.wd_enable, bus.wd_heartbeat,
                   bus.wd_force_reset, bus.rf_mute, bus.lockout};
            exp = {3'(m_state), 3'(m_retry), m_missed, m_state == 2, m_hb, m_state == 1, m_state != 2, m_state == 4};
            n_cmp++;
            if (got !== exp) begin n_bad++; $display("FAIL rand_outputs cyc=%0d got=%h exp=%h", c, got, exp); end
`ifdef WD_SUPERVISOR_STATS_EN
            n_cmp++;
            if ({bus.fault_count, bus.miss_count} !== {16'(m_faults), 16'(m_misses)}) begin
                n_bad++; $display("FAIL rand_stats cyc=%0d got=%0d/%0d exp=%0d/%0d", c, bus.fault_count, bus.miss_count, m_faults, m_misses);
            end
`endif
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_arm();
        test_heartbeat();
        test_timeout();
        test_fault();
        test_lockout();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
